time_keeper: RTL
================

Name: time_keeper

Overview:
Runs the wall-clock time that the time-setting interface edits. It divides the system clock down to a 1 Hz tick and counts seconds, minutes and hours in 24-hour format. A new hours/minutes value is taken through a single-cycle load strobe from the setting logic. It also drives BCD copies of hours and minutes, plus rollover strobes, for the display and alarm blocks.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second; minimum 2; simulation uses 4.
PRESCALE_W, 26, prescaler width; must satisfy 2**PRESCALE_W >= TICKS_PER_SEC.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
run_en  input  1  1 = time advances; 0 = frozen (held low while the user is setting time).
load_en  input  1  one-cycle strobe; take load_hours/load_mins.
load_hours  input  8  binary hours to load, valid range 0..23.
load_mins  input  8  binary minutes to load, valid range 0..59.
hours  output  8  binary hours, 0..23.
mins  output  8  binary minutes, 0..59.
secs  output  8  binary seconds, 0..59.
hours_bcd  output  8  {tens[3:0], ones[3:0]} of hours.
mins_bcd  output  8  {tens[3:0], ones[3:0]} of mins.
sec_pulse  output  1  one-cycle strobe on each second increment.
min_rollover  output  1  one-cycle strobe when secs wraps from 59 to 0.
day_rollover  output  1  one-cycle strobe when time wraps from 23:59:59 to 00:00:00.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0 and hours=mins=secs=0. hours_bcd=mins_bcd=8'h00. All strobes are 0.
- Prescaler:
  - Increments every cycle while run_en=1. Holds its value while run_en=0.
  - At TICKS_PER_SEC-1 it wraps to 0 and generates an internal tick in that same cycle.
- On a tick, all updates are registered and visible the next cycle:
  - secs increments. At 59, secs wraps to 0 and mins increments.
  - At mins 59, mins wraps to 0 and hours increments.
  - At hours 23, hours wraps to 0.
- Strobes:
  - sec_pulse is registered and high for the one cycle after each tick.
  - min_rollover and day_rollover are registered and coincide with the sec_pulse of the wrapping tick.
  - All strobes are 0 while run_en=0.
- Load (load_en=1), registered with one-cycle latency:
  - hours takes load_hours only if load_hours<=23; otherwise hours keeps its value.
  - mins takes load_mins only if load_mins<=59; otherwise mins keeps its value.
  - secs is cleared to 0 and the prescaler is cleared to 0, regardless of whether the fields were in range.
  - Load works whether run_en is 0 or 1.
- Load and tick in the same cycle: load wins. The tick is discarded, and sec_pulse and both rollover strobes stay 0 that cycle.
- load_en held high for several cycles: the load repeats every cycle, so time does not advance.
- BCD outputs:
  - Combinational conversion of the registered hours/mins, so they update in the same cycle as the binary values.
  - tens = value/10, ones = value%10, computed on 7-bit quantities.
- Counter arithmetic: comparisons use equality with the terminal value. The fields never hold out-of-range values, so no modulo hardware is needed.
- Reset asserted mid-second: everything returns immediately to the reset values. Counting restarts from prescaler 0 on the first clock after release.

Decomposition:
- Package time_pkg holds:
  - constants HOURS_MAX=23, MINS_MAX=59, SECS_MAX=59;
  - typedef bcd2_t = struct packed {logic [3:0] tens; logic [3:0] ones;}.
- Sub-module bin2bcd2: converts 0..99 binary to bcd2_t, purely combinational. Instantiate it twice, once for hours and once for mins.

Test Plan (TICKS_PER_SEC=4):
1. Reset with run_en=1 -> first sec_pulse 4 cycles after reset release; secs=1 and outputs read 00:00:01 the cycle after the tick; after 240 cycles mins=1, secs=0, min_rollover pulsed once.
2. load_en with load_hours=23, load_mins=59, then 60 seconds of ticks -> hours=0, mins=0, secs=0; day_rollover and min_rollover high in the same cycle; hours_bcd=8'h00.
3. load_hours=12, load_mins=34 -> next cycle hours=12, mins=34, secs=0, hours_bcd=8'h12, mins_bcd=8'h34. Then load_hours=30, load_mins=61 -> hours=12, mins=34 unchanged, secs=0.
4. run_en=0 held for 20 cycles mid-second (prescaler=2) -> no strobes and all outputs frozen; after run_en returns to 1, the tick arrives 2 cycles later.
5. load_en asserted in the cycle where prescaler=3 with load_hours=5, load_mins=6 -> no sec_pulse; outputs 05:06:00; the next tick comes 4 cycles later.
6. reset driven low asynchronously mid-cycle at 10:20:30 -> outputs go to 0 before the next clk edge and the strobes drop to 0.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// time_pkg: shared constants and types for the time_keeper slice.
//   HOURS_MAX/MINS_MAX/SECS_MAX : terminal values of the time fields
//   bcd2_t                      : two-digit BCD value {tens, ones}
package time_pkg;

    localparam logic [7:0] HOURS_MAX = 8'd23;
    localparam logic [7:0] MINS_MAX  = 8'd59;
    localparam logic [7:0] SECS_MAX  = 8'd59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

endpackage

// File: rtl/time_keeper_bin2bcd2.sv
// bin2bcd2: combinational binary (0..99) to two-digit BCD converter.
//   bin_i : 7-bit binary value, 0..99
//   bcd_o : {tens, ones} BCD digits
module bin2bcd2
    import time_pkg::*;
(
    input  logic [6:0] bin_i,
    output bcd2_t      bcd_o
);

    always_comb begin
        bcd_o.tens = 4'(bin_i / 7'd10);
        bcd_o.ones = 4'(bin_i % 7'd10);
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24-hour wall clock driven by a 1 Hz tick divided from clk.
//   clk, reset (async, active-low)
//   run_en                 : 1 = time advances, 0 = frozen
//   load_en                : one-cycle strobe, loads load_hours/load_mins
//                            (out-of-range fields ignored), clears secs
//                            and the prescaler
//   hours/mins/secs        : binary time fields
//   hours_bcd/mins_bcd     : combinational BCD copies of hours/mins
//   sec_pulse              : one cycle after each counted second
//   min_rollover           : with sec_pulse when secs wraps 59 -> 0
//   day_rollover           : with sec_pulse when 23:59:59 -> 00:00:00
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned PRESCALE_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       load_en,
    input  logic [7:0] load_hours,
    input  logic [7:0] load_mins,
    output logic [7:0] hours,
    output logic [7:0] mins,
    output logic [7:0] secs,
    output logic [7:0] hours_bcd,
    output logic [7:0] mins_bcd,
    output logic       sec_pulse,
    output logic       min_rollover,
    output logic       day_rollover
);

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [7:0]            hours_q, hours_d;
    logic [7:0]            mins_q, mins_d;
    logic [7:0]            secs_q, secs_d;
    logic                  sec_pulse_q, sec_pulse_d;
    logic                  min_roll_q, min_roll_d;
    logic                  day_roll_q, day_roll_d;
    logic                  tick;

    always_comb begin
        tick = run_en && (prescale_q == PRESCALE_W'(TICKS_PER_SEC - 1));
    end

    always_comb begin
        prescale_d  = prescale_q;
        hours_d     = hours_q;
        mins_d      = mins_q;
        secs_d      = secs_q;
        sec_pulse_d = 1'b0;
        min_roll_d  = 1'b0;
        day_roll_d  = 1'b0;
        if (load_en) begin
            // Load has priority: any coincident tick is dropped.
            if (load_hours <= HOURS_MAX) hours_d = load_hours;
            if (load_mins  <= MINS_MAX)  mins_d  = load_mins;
            secs_d     = '0;
            prescale_d = '0;
        end else if (run_en) begin
            if (tick) begin
                prescale_d  = '0;
                sec_pulse_d = 1'b1;
                if (secs_q == SECS_MAX) begin
                    secs_d     = '0;
                    min_roll_d = 1'b1;
                    if (mins_q == MINS_MAX) begin
                        mins_d = '0;
                        if (hours_q == HOURS_MAX) begin
                            hours_d    = '0;
                            day_roll_d = 1'b1;
                        end else begin
                            hours_d = hours_q + 8'd1;
                        end
                    end else begin
                        mins_d = mins_q + 8'd1;
                    end
                end else begin
                    secs_d = secs_q + 8'd1;
                end
            end else begin
                prescale_d = prescale_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q  <= '0;
            hours_q     <= '0;
            mins_q      <= '0;
            secs_q      <= '0;
            sec_pulse_q <= 1'b0;
            min_roll_q  <= 1'b0;
            day_roll_q  <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            hours_q     <= hours_d;
            mins_q      <= mins_d;
            secs_q      <= secs_d;
            sec_pulse_q <= sec_pulse_d;
            min_roll_q  <= min_roll_d;
            day_roll_q  <= day_roll_d;
        end
    end

    bin2bcd2 u_hours_bcd (
        .bin_i (hours_q[6:0]),
        .bcd_o (hours_bcd)
    );

    bin2bcd2 u_mins_bcd (
        .bin_i (mins_q[6:0]),
        .bcd_o (mins_bcd)
    );

    assign hours        = hours_q;
    assign mins         = mins_q;
    assign secs         = secs_q;
    assign sec_pulse    = sec_pulse_q;
    assign min_rollover = min_roll_q;
    assign day_rollover = day_roll_q;

endmodule
